multi_cycle_ctr: RTL and testbench
==================================

MULTI_CYCLE_CTR -- requirements
Module: multi_cycle_ctr

Interface
REQ-001 The block SHALL have a single clock, clk, rising-edge active; reset is synchronous and active-high.
REQ-002 Port clk, input, 1 bit: system clock.
REQ-003 Port reset, input, 1 bit: synchronous active-high reset.
REQ-004 Port opCode, input, 6 bits: instruction register bits [31:26], valid from DECODE onward.
REQ-005 Port memReady, input, 1 bit: memory access completes in the current cycle.
REQ-006 Write-enable outputs SHALL each be 1 bit: pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regWrite, regDst, aluSrcA.
REQ-007 Multi-bit outputs SHALL be aluSrcB [1:0] (00 regB, 01 const 4, 10 signext imm, 11 signext imm<<2), aluOp [1:0] (00 add, 01 sub, 10 funct-decoded) and pcSource [1:0] (00 ALU result, 01 ALUOut, 10 jump target).
REQ-008 Output state, 4 bits, SHALL expose the current state encoding for debug.

Function
REQ-009 The block SHALL be a Moore FSM; the only Mealy terms are memReady gating in memory states.
REQ-010 Encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9; codes 10-15 are illegal.
REQ-011 FETCH: iorD=0, memRead=1, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00; irWrite=pcWrite=memReady; advance to DECODE only when memReady=1, else hold.
REQ-012 DECODE: aluSrcA=0, aluSrcB=11, aluOp=00; next state by opCode: 100011/101011 -> MEM_ADDR, 000000 -> EXECUTE, 000100 -> BRANCH, 000010 -> JUMP, other -> FETCH.
REQ-013 MEM_ADDR: aluSrcA=1, aluSrcB=10, aluOp=00; next MEM_READ if opCode=100011, else MEM_WRITE.
REQ-014 MEM_READ: iorD=1, memRead=1; advance to MEM_WB when memReady=1, else hold.
REQ-015 MEM_WB: regDst=0, memToReg=1, regWrite=1; next FETCH.
REQ-016 MEM_WRITE: iorD=1, memWrite=1; advance to FETCH when memReady=1, else hold with memWrite still 1.
REQ-017 EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=10; next R_WB.
REQ-018 R_WB: regDst=1, memToReg=0, regWrite=1; next FETCH.
REQ-019 BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01; next FETCH.
REQ-020 JUMP: pcWrite=1, pcSource=10; next FETCH.
REQ-021 Every output not listed for a state SHALL be 0.
REQ-022 Illegal state codes SHALL drive all outputs 0 and return to FETCH on the next edge.
REQ-023 Latency with memReady always 1: lw 5 cycles, sw 4, R-type 4, beq 3, j 3, unknown opcode 2.
REQ-024 opCode SHALL be sampled only in DECODE and MEM_ADDR; changes in other states SHALL have no effect.

Reset
REQ-025 reset=1 at a clock edge SHALL force state to FETCH regardless of current state, including mid-stall.
REQ-026 While reset=1, all write-enable outputs (pcWrite, pcWriteCond, memWrite, irWrite, regWrite) and memRead SHALL be 0.
REQ-027 After reset deassertion, the first cycle SHALL be FETCH with outputs per REQ-011.

Structure
REQ-028 State encodings, opcode constants (R 000000, LW 100011, SW 101011, BEQ 000100, J 000010) and the aluOp/aluSrcB/pcSource codes SHALL reside in a shared package.
REQ-029 The block SHALL be split into a state register plus next-state logic, and one sub-module, mc_out_decode, mapping state and memReady to outputs.

Verification
REQ-030 Reset, then opCode=100011, memReady=1 -> states 0,1,2,3,4,0; regWrite=1 and memToReg=1 only in state 4.
REQ-031 opCode=101011, memReady=0 for 3 cycles in MEM_WRITE -> state holds at 5 for 3 cycles with memWrite=1, then returns to 0.
REQ-032 opCode=000000 -> states 0,1,6,7,0; aluOp=10 in state 6; regDst=1 and regWrite=1 in state 7.
REQ-033 opCode=000100 then 000010 -> beq path 0,1,8 with pcWriteCond=1 and pcSource=01; j path 0,1,9 with pcWrite=1 and pcSource=10.
REQ-034 opCode=111111 -> states 0,1,0 with no write enable ever asserted.
REQ-035 reset=1 asserted in MEM_READ while memReady=0 -> state 0 next cycle, all write enables 0 during reset.

Source files
------------

// File: rtl/multi_cycle_ctr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_cycle_ctr_pkg : shared state, opcode and datapath-select codes |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package multi_cycle_ctr_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multi_cycle_ctr_out_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_out_decode : maps controller state (and memReady) to control lines|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mc_out_decode
  import multi_cycle_ctr_pkg::*;
(
  input  logic [3:0] state,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regWrite,
  output logic       regDst,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource
);

  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regWrite    = 1'b0;
    regDst      = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = SRCB_REG;
    aluOp       = ALU_OP_ADD;
    pcSource    = PC_SRC_ALU;
    case (state)
      S_FETCH: begin
        // IR load and PC+4 only commit on the cycle memory delivers
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        irWrite = memReady;
        pcWrite = memReady;
      end
      S_DECODE: aluSrcB = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      S_MEM_READ: begin
        iorD    = 1'b1;
        memRead = 1'b1;
      end
      S_MEM_WB: begin
        memToReg = 1'b1;
        regWrite = 1'b1;
      end
      S_MEM_WRITE: begin
        iorD     = 1'b1;
        memWrite = 1'b1;
      end
      S_EXECUTE: begin
        aluSrcA = 1'b1;
        aluOp   = ALU_OP_FUNCT;
      end
      S_R_WB: begin
        regDst   = 1'b1;
        regWrite = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = ALU_OP_SUB;
        pcWriteCond = 1'b1;
        pcSource    = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        pcWrite  = 1'b1;
        pcSource = PC_SRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_cycle_ctr : Moore control FSM for a multi-cycle MIPS datapath  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module multi_cycle_ctr
  import multi_cycle_ctr_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regWrite,
  output logic       regDst,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic [3:0] state
);

  state_t r_state;
  state_t w_nextState;

  logic w_pcWrite, w_pcWriteCond, w_memRead, w_memWrite, w_irWrite, w_regWrite;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = S_FETCH;
    case (r_state)
      S_FETCH:     w_nextState = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opCode)
          OP_LW, OP_SW: w_nextState = S_MEM_ADDR;
          OP_R:         w_nextState = S_EXECUTE;
          OP_BEQ:       w_nextState = S_BRANCH;
          OP_J:         w_nextState = S_JUMP;
          default:      w_nextState = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  w_nextState = (opCode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  w_nextState = memReady ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    w_nextState = S_FETCH;
      S_MEM_WRITE: w_nextState = memReady ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   w_nextState = S_R_WB;
      S_R_WB:      w_nextState = S_FETCH;
      S_BRANCH:    w_nextState = S_FETCH;
      S_JUMP:      w_nextState = S_FETCH;
      default:     w_nextState = S_FETCH;
    endcase
  end

  mc_out_decode u_outDecode (
    .state       (r_state),
    .memReady    (memReady),
    .pcWrite     (w_pcWrite),
    .pcWriteCond (w_pcWriteCond),
    .iorD        (iorD),
    .memRead     (w_memRead),
    .memWrite    (w_memWrite),
    .irWrite     (w_irWrite),
    .memToReg    (memToReg),
    .regWrite    (w_regWrite),
    .regDst      (regDst),
    .aluSrcA     (aluSrcA),
    .aluSrcB     (aluSrcB),
    .aluOp       (aluOp),
    .pcSource    (pcSource)
  );

  // Side-effecting strobes are masked for the whole reset cycle, not just after it
  assign pcWrite     = w_pcWrite     & ~reset;
  assign pcWriteCond = w_pcWriteCond & ~reset;
  assign memRead     = w_memRead     & ~reset;
  assign memWrite    = w_memWrite    & ~reset;
  assign irWrite     = w_irWrite     & ~reset;
  assign regWrite    = w_regWrite    & ~reset;

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multi_cycle_ctr : table-driven + scoreboard bench for the FSM     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_multi_cycle_ctr;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opCode = 6'd0;
  logic       memReady = 1'b1;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memToReg, regWrite, regDst, aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] state;

  multi_cycle_ctr dut (
    .clk(clk), .reset(reset), .opCode(opCode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .memToReg(memToReg), .regWrite(regWrite), .regDst(regDst),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSource(pcSource), .state(state)
  );

  always #5 clk = ~clk;

  logic [15:0] dutOut;
  assign dutOut = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                   memToReg, regWrite, regDst, aluSrcA, aluSrcB, aluOp, pcSource};

  typedef struct {
    logic        chk;
    logic [3:0]  st;
    logic [15:0] out;
    string       tag;
  } exp_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    int          n;
    logic [23:0] seq;
  } vec_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Expected control word, written directly from the per-state output table
  function automatic logic [15:0] expOut(input logic [3:0] st, input logic mr, input logic rst);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rw, rd, sa;
    logic [1:0] sb, ao, ps;
    pw = 0; pwc = 0; iod = 0; mrd = 0; mwr = 0; irw = 0;
    m2r = 0; rw = 0; rd = 0; sa = 0; sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      4'd0: begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      4'd1: sb = 2'b11;
      4'd2: begin sa = 1; sb = 2'b10; end
      4'd3: begin iod = 1; mrd = 1; end
      4'd4: begin m2r = 1; rw = 1; end
      4'd5: begin iod = 1; mwr = 1; end
      4'd6: begin sa = 1; ao = 2'b10; end
      4'd7: begin rd = 1; rw = 1; end
      4'd8: begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      4'd9: begin pw = 1; ps = 2'b10; end
      default: ;
    endcase
    if (rst) begin pw = 0; pwc = 0; mrd = 0; mwr = 0; irw = 0; rw = 0; end
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rw, rd, sa, sb, ao, ps};
  endfunction

  task automatic cyc(input logic rst, input logic [5:0] op, input logic mr,
                     input logic chk, input logic [3:0] st, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; opCode = op; memReady = mr;
    e.chk = chk; e.st = st; e.out = expOut(st, mr, rst); e.tag = tag;
    q.push_back(e);
  endtask

  // Two reset cycles: the first has an unknown prior state, the second must show FETCH
  task automatic doReset(input logic [5:0] op);
    cyc(1'b1, op, 1'b1, 1'b0, 4'd0, "rst0");
    cyc(1'b1, op, 1'b1, 1'b1, 4'd0, "rst");
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.chk) begin
        checks++;
        if (state !== e.st) begin
          errors++;
          $display("FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
        end
        checks++;
        if (dutOut !== e.out) begin
          errors++;
          $display("FAIL %s outputs (st %0d): got %b expected %b", e.tag, e.st, dutOut, e.out);
        end
      end
    end
  end

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"lw",   6'b100011, 6, {4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}};
    vecs[1] = '{"sw",   6'b101011, 5, {4'd0, 4'd0, 4'd5, 4'd2, 4'd1, 4'd0}};
    vecs[2] = '{"rtype",6'b000000, 5, {4'd0, 4'd0, 4'd7, 4'd6, 4'd1, 4'd0}};
    vecs[3] = '{"beq",  6'b000100, 4, {4'd0, 4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};
    vecs[4] = '{"j",    6'b000010, 4, {4'd0, 4'd0, 4'd0, 4'd9, 4'd1, 4'd0}};
    vecs[5] = '{"unk",  6'b111111, 3, {4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0}};

    for (int v = 0; v < 6; v++) begin
      logic [23:0] s;
      s = vecs[v].seq;
      doReset(vecs[v].op);
      for (int i = 0; i < vecs[v].n; i++)
        cyc(1'b0, vecs[v].op, 1'b1, 1'b1, s[4*i +: 4], vecs[v].name);
    end

    // sw with three stalled cycles in MEM_WRITE
    doReset(6'b101011);
    cyc(0, 6'b101011, 1, 1, 4'd0, "swStall");
    cyc(0, 6'b101011, 1, 1, 4'd1, "swStall");
    cyc(0, 6'b101011, 1, 1, 4'd2, "swStall");
    cyc(0, 6'b101011, 0, 1, 4'd5, "swStall");
    cyc(0, 6'b101011, 0, 1, 4'd5, "swStall");
    cyc(0, 6'b101011, 0, 1, 4'd5, "swStall");
    cyc(0, 6'b101011, 1, 1, 4'd5, "swStall");
    cyc(0, 6'b101011, 1, 1, 4'd0, "swStall");

    // FETCH stall, then opCode changed during MEM_READ must be ignored
    doReset(6'b100011);
    cyc(0, 6'b100011, 0, 1, 4'd0, "lwOpChg");
    cyc(0, 6'b100011, 0, 1, 4'd0, "lwOpChg");
    cyc(0, 6'b100011, 1, 1, 4'd0, "lwOpChg");
    cyc(0, 6'b100011, 1, 1, 4'd1, "lwOpChg");
    cyc(0, 6'b100011, 1, 1, 4'd2, "lwOpChg");
    cyc(0, 6'b000000, 0, 1, 4'd3, "lwOpChg");
    cyc(0, 6'b000000, 1, 1, 4'd3, "lwOpChg");
    cyc(0, 6'b000000, 1, 1, 4'd4, "lwOpChg");
    cyc(0, 6'b000000, 1, 1, 4'd0, "lwOpChg");

    // reset asserted while stalled in MEM_READ
    doReset(6'b100011);
    cyc(0, 6'b100011, 1, 1, 4'd0, "rstStall");
    cyc(0, 6'b100011, 1, 1, 4'd1, "rstStall");
    cyc(0, 6'b100011, 1, 1, 4'd2, "rstStall");
    cyc(0, 6'b100011, 0, 1, 4'd3, "rstStall");
    cyc(1, 6'b100011, 0, 1, 4'd3, "rstStall");
    cyc(0, 6'b000000, 1, 1, 4'd0, "rstStall");
    cyc(0, 6'b000000, 1, 1, 4'd1, "rstStall");
    cyc(0, 6'b000000, 1, 1, 4'd6, "rstStall");

    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
